traffic_phase_scheduler: RTL

Timed right-of-way scheduler for a two-road intersection (road A = main, road B = side) with a pedestrian walk phase and road-A emergency preemption. It replaces untimed sensor-only sequencing with tick-based minimum/maximum green, yellow and all-red intervals. It drives the six lamp outputs plus a walk lamp directly, and sits between the sensor/button inputs and the lamp drivers.

---
 rtl/traffic_phase_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/traffic_phase_scheduler.sv
// Timed right-of-way scheduler for a main/side road intersection with a
// pedestrian walk phase and emergency preemption toward road A.
module traffic_phase_scheduler #(
    parameter int CW        = 5,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_req,
    input  logic       emg,
    output logic       Ra,
    output logic       Ya,
    output logic       Ga,
    output logic       Rb,
    output logic       Yb,
    output logic       Gb,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        AR_AB = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        AR_BA = 3'd5,
        WALK  = 3'd6
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] GMIN    = CW'(GREEN_MIN);
    localparam logic [CW-1:0] GMAX    = CW'(GREEN_MAX);
    localparam logic [CW-1:0] YEL     = CW'(YELLOW_T);
    localparam logic [CW-1:0] ARED    = CW'(ALLRED_T);
    localparam logic [CW-1:0] WLK     = CW'(WALK_T);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ped_q, ped_d;
    logic            from_a_q, from_a_d;
    logic            ack_q, ack_d;
    logic            walk_entry;

    always_comb begin
        state_d  = state_q;
        from_a_d = from_a_q;
        case (state_q)
            A_GRN: if (cnt_q >= GMIN && (Tb || ped_q) && (!Ta || cnt_q >= GMAX) && !emg)
                       state_d = A_YEL;
            A_YEL: if (cnt_q == YEL) state_d = AR_AB;
            AR_AB: if (cnt_q == ARED) begin
                       if (emg) begin
                           state_d = AR_BA;
                       end else if (ped_q) begin
                           state_d  = WALK;
                           from_a_d = 1'b1;
                       end else begin
                           state_d = B_GRN;
                       end
                   end
            // Emergency cuts side green short immediately; yellow still runs in full.
            B_GRN: if (emg || (cnt_q >= GMIN && !Tb) || (cnt_q >= GMAX && (Ta || ped_q)))
                       state_d = B_YEL;
            B_YEL: if (cnt_q == YEL) state_d = AR_BA;
            AR_BA: if (cnt_q == ARED) begin
                       if (emg) begin
                           state_d = A_GRN;
                       end else if (ped_q) begin
                           state_d  = WALK;
                           from_a_d = 1'b0;
                       end else begin
                           state_d = A_GRN;
                       end
                   end
            WALK:  if (cnt_q == WLK) state_d = (from_a_q && !emg) ? B_GRN : A_GRN;
            default: state_d = A_GRN;
        endcase
    end

    // Entering WALK consumes the pending request even if the button is still held.
    assign walk_entry = (state_d == WALK) && (state_q != WALK);
    assign ped_d      = walk_entry ? 1'b0 : (ped_q | ped_req);
    assign ack_d      = walk_entry;

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (tick && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= A_GRN;
            cnt_q    <= '0;
            ped_q    <= 1'b0;
            from_a_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ped_q    <= ped_d;
            from_a_q <= from_a_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        Ra   = 1'b0;
        Ya   = 1'b0;
        Ga   = 1'b0;
        Rb   = 1'b0;
        Yb   = 1'b0;
        Gb   = 1'b0;
        walk = 1'b0;
        case (state_q)
            A_GRN: begin Ga = 1'b1; Rb = 1'b1; end
            A_YEL: begin Ya = 1'b1; Rb = 1'b1; end
            B_GRN: begin Ra = 1'b1; Gb = 1'b1; end
            B_YEL: begin Ra = 1'b1; Yb = 1'b1; end
            WALK:  begin Ra = 1'b1; Rb = 1'b1; walk = 1'b1; end
            default: begin Ra = 1'b1; Rb = 1'b1; end
        endcase
    end

    assign ped_ack = ack_q;
    assign phase   = state_q;

endmodule
